traffic_light_monitor: RTL and testbench
========================================

Name: traffic_light_monitor

Overview:
- Receive-side checker for the 10-bit `light` bus driven by TrafficLight_CU.
- Decodes the LED pattern into a phase index and measures how long each phase is held.
- Checks pattern legality, phase ordering and minimum yellow/all-red dwell, and raises sticky error flags.
- Sits beside the CU in the FPGA top level and in benches, as the passive consumer of `light`.

Parameters:
- DW, 16: width of the dwell counters.
- MIN_YELLOW, 30: minimum legal yellow dwell, in cycles.
- MIN_ALLRED, 10: minimum legal all-red dwell, in cycles.
- ALLOW_LEFT_SKIP, 1: if 1, GO may go directly to YEL, skipping LEFT.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-low reset (0 = reset).
- light, in, 10: CU LED bus. Bit map [0] NS_R, [1] NS_Y, [2] NS_G, [3] NS_LEFT, [4] EW_R, [5] EW_Y, [6] EW_G, [7] EW_LEFT, [8] NS_WALK, [9] EW_WALK.
- seq_check_en, in, 1: enables the ordering check.
- clr_err, in, 1: one-cycle pulse that clears the sticky errors.
- phase, out, 3: decoded phase, 0 to 6; 7 means unknown or illegal.
- phase_chg, out, 1: one-cycle pulse when `phase` changes.
- dwell, out, DW: cycles the current phase has been held; saturates at all-ones.
- last_dwell, out, DW: dwell of the most recently completed phase.
- err_flags, out, 4: sticky errors. [0] pattern, [1] sequence, [2] short yellow, [3] short all-red.
- err_any, out, 1: OR of err_flags.

Behaviour:
- Phase encodings; an exact match is required:
  - P0 ALLRED = 0x011
  - P1 NS_GO = 0x114
  - P2 NS_LEFT = 0x019
  - P3 NS_YEL = 0x012
  - P4 EW_GO = 0x241
  - P5 EW_LEFT = 0x091
  - P6 EW_YEL = 0x021
  - Any other value is illegal, including conflicting greens and all-off.
- Pipeline:
  - `light` is registered into light_q.
  - The decode of light_q is registered into `phase`.
  - `phase` reflects `light` with a 2-cycle latency.
- Legal successors:
  - 0 → 1 or 4
  - 1 → 2, or 3 if ALLOW_LEFT_SKIP
  - 2 → 3
  - 3 → 0
  - 4 → 5, or 6 if ALLOW_LEFT_SKIP
  - 5 → 6
  - 6 → 0
- FSM states: S_INIT, S_TRACK, S_FAULT.
  - S_INIT: a legal decode loads `phase`, sets dwell=1, pulses phase_chg and moves to S_TRACK. No sequence or dwell check is made on this entry.
  - S_TRACK, same phase: dwell increments, saturating.
  - S_TRACK, new legal phase:
    - phase_chg=1, last_dwell ← dwell, dwell ← 1.
    - If seq_check_en and the pair is not a legal successor, set err[1].
    - If leaving P3 or P6 with dwell < MIN_YELLOW, set err[2].
    - If leaving P0 with dwell < MIN_ALLRED, set err[3].
  - Illegal decode from any state:
    - Set err[0], phase ← 7, dwell ← 0, and pulse phase_chg if phase was not already 7.
    - Go to S_FAULT.
    - last_dwell captures the interrupted phase's dwell when leaving S_TRACK.
  - S_FAULT: stays while the decode is illegal. On a legal decode it behaves exactly like S_INIT, i.e. re-syncs without a sequence or dwell check.
- Error flags:
  - err_flags are set-only.
  - A clr_err pulse clears them on the next edge.
  - If a set and clr_err occur in the same cycle, the set wins for that bit; other bits clear.
- err_any is combinational from err_flags.
- Reset values: light_q = 0, phase = 7, phase_chg = 0, dwell = 0, last_dwell = 0, err_flags = 0, state S_INIT.
- Reset mid-phase discards all history. The pipeline refills, so the first legal phase appears 2 cycles after rst deasserts.
- seq_check_en deasserted disables only err[1]; the dwell checks remain active.
- The monitor never drives or back-pressures the CU.

Decomposition:
- Package traffic_light_pkg holds:
  - the LED bit-index constants;
  - the 10-bit encodings of the seven phases and PH_UNKNOWN = 3'd7;
  - the error-bit indices;
  - the FSM state encoding.
- The CU should import the same constants.
- Sub-module tl_phase_decode: combinational, 10-bit pattern → 3-bit phase, with 7 for illegal. It is reused by the display logic.

Test Plan:
- Hold 0x011 for 20 cycles, then cycle 0x114 (40) → 0x019 (40) → 0x012 (30) → 0x011 (20) → 0x241 (40) → 0x091 (40) → 0x021 (30) → 0x011.
  - phase steps 0,1,2,3,0,4,5,6,0 with 2-cycle latency.
  - phase_chg is one cycle per step.
  - last_dwell = 40 after P1 ends.
  - err_flags stays 0.
- Drive 0x114 then 0x012 with ALLOW_LEFT_SKIP=1 → no error. Repeat with parameter 0 → err_flags = 4'b0010.
- Hold 0x012 for 12 cycles, then 0x011 → err_flags[2]=1 and last_dwell=12.
- Drive 0x054 (both greens) → phase=7, err_flags[0]=1. Then 0x241 → phase=4, no err[1], dwell restarts at 1.
- Drive 0x114 → 0x241 with seq_check_en=0 → no err[1]. Then pulse clr_err in the same cycle as a short all-red exit → err[3] remains set and all other bits clear.
- Assert rst=0 mid P4 for 3 cycles → all outputs at reset values, phase=7. After release with light=0x011, phase=0 two cycles later.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// Shared constants for the traffic light controller and its monitor:
// LED bit map, phase encodings, error-bit indices and the monitor FSM states.
package traffic_light_pkg;

    localparam int LED_NS_R    = 0;
    localparam int LED_NS_Y    = 1;
    localparam int LED_NS_G    = 2;
    localparam int LED_NS_LEFT = 3;
    localparam int LED_EW_R    = 4;
    localparam int LED_EW_Y    = 5;
    localparam int LED_EW_G    = 6;
    localparam int LED_EW_LEFT = 7;
    localparam int LED_NS_WALK = 8;
    localparam int LED_EW_WALK = 9;

    localparam logic [9:0] PAT_ALLRED  = 10'((1 << LED_NS_R) | (1 << LED_EW_R));
    localparam logic [9:0] PAT_NS_GO   = 10'((1 << LED_NS_G) | (1 << LED_EW_R) | (1 << LED_NS_WALK));
    localparam logic [9:0] PAT_NS_LEFT = 10'((1 << LED_NS_R) | (1 << LED_NS_LEFT) | (1 << LED_EW_R));
    localparam logic [9:0] PAT_NS_YEL  = 10'((1 << LED_NS_Y) | (1 << LED_EW_R));
    localparam logic [9:0] PAT_EW_GO   = 10'((1 << LED_NS_R) | (1 << LED_EW_G) | (1 << LED_EW_WALK));
    localparam logic [9:0] PAT_EW_LEFT = 10'((1 << LED_NS_R) | (1 << LED_EW_R) | (1 << LED_EW_LEFT));
    localparam logic [9:0] PAT_EW_YEL  = 10'((1 << LED_NS_R) | (1 << LED_EW_Y));

    localparam logic [2:0] PH_ALLRED  = 3'd0;
    localparam logic [2:0] PH_NS_GO   = 3'd1;
    localparam logic [2:0] PH_NS_LEFT = 3'd2;
    localparam logic [2:0] PH_NS_YEL  = 3'd3;
    localparam logic [2:0] PH_EW_GO   = 3'd4;
    localparam logic [2:0] PH_EW_LEFT = 3'd5;
    localparam logic [2:0] PH_EW_YEL  = 3'd6;
    localparam logic [2:0] PH_UNKNOWN = 3'd7;

    localparam int ERR_PATTERN = 0;
    localparam int ERR_SEQ     = 1;
    localparam int ERR_YELLOW  = 2;
    localparam int ERR_ALLRED  = 3;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_TRACK = 2'd1,
        S_FAULT = 2'd2
    } mon_state_t;

    function automatic logic legal_successor(input logic [2:0] from_ph,
                                             input logic [2:0] to_ph,
                                             input logic       allow_skip);
        case (from_ph)
            PH_ALLRED:  return (to_ph == PH_NS_GO) || (to_ph == PH_EW_GO);
            PH_NS_GO:   return (to_ph == PH_NS_LEFT) || (allow_skip && (to_ph == PH_NS_YEL));
            PH_NS_LEFT: return (to_ph == PH_NS_YEL);
            PH_NS_YEL:  return (to_ph == PH_ALLRED);
            PH_EW_GO:   return (to_ph == PH_EW_LEFT) || (allow_skip && (to_ph == PH_EW_YEL));
            PH_EW_LEFT: return (to_ph == PH_EW_YEL);
            PH_EW_YEL:  return (to_ph == PH_ALLRED);
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tl_phase_decode.sv
// Exact-match decode of the 10-bit LED bus into a phase index; anything
// that is not one of the seven legal patterns decodes to PH_UNKNOWN.
module tl_phase_decode
    import traffic_light_pkg::*;
(
    input  logic [9:0] pattern,
    output logic [2:0] phase
);

    always_comb begin
        phase = PH_UNKNOWN;
        case (pattern)
            PAT_ALLRED:  phase = PH_ALLRED;
            PAT_NS_GO:   phase = PH_NS_GO;
            PAT_NS_LEFT: phase = PH_NS_LEFT;
            PAT_NS_YEL:  phase = PH_NS_YEL;
            PAT_EW_GO:   phase = PH_EW_GO;
            PAT_EW_LEFT: phase = PH_EW_LEFT;
            PAT_EW_YEL:  phase = PH_EW_YEL;
            default:     phase = PH_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker of the CU light bus: tracks phase and dwell, and raises
// sticky errors for illegal patterns, bad ordering and short yellow/all-red.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int DW              = 16,
    parameter int MIN_YELLOW      = 30,
    parameter int MIN_ALLRED      = 10,
    parameter int ALLOW_LEFT_SKIP = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    light,
    input  logic          seq_check_en,
    input  logic          clr_err,
    output logic [2:0]    phase,
    output logic          phase_chg,
    output logic [DW-1:0] dwell,
    output logic [DW-1:0] last_dwell,
    output logic [3:0]    err_flags,
    output logic          err_any
);

    localparam logic [DW-1:0] MIN_YEL_C = DW'(MIN_YELLOW);
    localparam logic [DW-1:0] MIN_AR_C  = DW'(MIN_ALLRED);
    localparam logic          SKIP_OK   = (ALLOW_LEFT_SKIP != 0);

    function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] v);
        return (&v) ? v : v + DW'(1);
    endfunction

    mon_state_t    state, state_n;
    logic [9:0]    light_q;
    logic          vld_p0;
    logic [2:0]    dec_phase;
    logic [2:0]    phase_n;
    logic          chg_n;
    logic [DW-1:0] dwell_n, last_n;
    logic [3:0]    err_set, err_n;

    // Stage 0: register the bus; vld_p0 marks light_q as holding post-reset data
    always_ff @(posedge clk) begin
        if (!rst) begin
            light_q <= '0;
            vld_p0  <= 1'b0;
        end else begin
            light_q <= light;
            vld_p0  <= 1'b1;
        end
    end

    tl_phase_decode u_decode (
        .pattern (light_q),
        .phase   (dec_phase)
    );

    // Stage 1: FSM, dwell tracking and error detection on the decoded phase
    always_comb begin
        state_n = state;
        phase_n = phase;
        chg_n   = 1'b0;
        dwell_n = dwell;
        last_n  = last_dwell;
        err_set = '0;
        if (vld_p0) begin
            if (dec_phase == PH_UNKNOWN) begin
                err_set[ERR_PATTERN] = 1'b1;
                phase_n = PH_UNKNOWN;
                dwell_n = '0;
                chg_n   = (phase != PH_UNKNOWN);
                if (state == S_TRACK)
                    last_n = dwell;
                state_n = S_FAULT;
            end else if (state != S_TRACK) begin
                // Entry and re-sync: no ordering or dwell judgement on a phase never seen start
                phase_n = dec_phase;
                dwell_n = DW'(1);
                chg_n   = 1'b1;
                state_n = S_TRACK;
            end else if (dec_phase == phase) begin
                dwell_n = sat_inc(dwell);
            end else begin
                phase_n = dec_phase;
                dwell_n = DW'(1);
                last_n  = dwell;
                chg_n   = 1'b1;
                if (seq_check_en && !legal_successor(phase, dec_phase, SKIP_OK))
                    err_set[ERR_SEQ] = 1'b1;
                if (((phase == PH_NS_YEL) || (phase == PH_EW_YEL)) && (dwell < MIN_YEL_C))
                    err_set[ERR_YELLOW] = 1'b1;
                if ((phase == PH_ALLRED) && (dwell < MIN_AR_C))
                    err_set[ERR_ALLRED] = 1'b1;
            end
        end
        err_n = (err_flags & ~{4{clr_err}}) | err_set;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_INIT;
            phase      <= PH_UNKNOWN;
            phase_chg  <= 1'b0;
            dwell      <= '0;
            last_dwell <= '0;
            err_flags  <= '0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            phase_chg  <= chg_n;
            dwell      <= dwell_n;
            last_dwell <= last_n;
            err_flags  <= err_n;
        end
    end

    assign err_any = |err_flags;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor with a second instance built
// without left-turn skipping.
module tb_traffic_light_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  light;
    logic        seq_check_en;
    logic        clr_err;
    logic        mirror;
    logic [9:0]  light_b;

    logic [2:0]  phase,      phase_b;
    logic        phase_chg,  phase_chg_b;
    logic [15:0] dwell,      dwell_b;
    logic [15:0] last_dwell, last_dwell_b;
    logic [3:0]  err_flags,  err_flags_b;
    logic        err_any,    err_any_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign light_b = mirror ? light : 10'h011;

    traffic_light_monitor #(.DW(16), .MIN_YELLOW(30), .MIN_ALLRED(10), .ALLOW_LEFT_SKIP(1)) dut (
        .clk(clk), .rst(rst), .light(light), .seq_check_en(seq_check_en), .clr_err(clr_err),
        .phase(phase), .phase_chg(phase_chg), .dwell(dwell), .last_dwell(last_dwell),
        .err_flags(err_flags), .err_any(err_any)
    );

    traffic_light_monitor #(.DW(16), .MIN_YELLOW(30), .MIN_ALLRED(10), .ALLOW_LEFT_SKIP(0)) dut_noskip (
        .clk(clk), .rst(rst), .light(light_b), .seq_check_en(seq_check_en), .clr_err(clr_err),
        .phase(phase_b), .phase_chg(phase_chg_b), .dwell(dwell_b), .last_dwell(last_dwell_b),
        .err_flags(err_flags_b), .err_any(err_any_b)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold pat for n cycles; checks the phase entry two cycles after the change
    task automatic drive_phase(input logic [9:0] pat, input int n,
                               input logic [2:0] exp_ph, input int exp_last);
        light = pat;
        tick(2);
        chk("phase", {29'd0, phase}, {29'd0, exp_ph});
        chk("phase_chg_on", {31'd0, phase_chg}, 32'd1);
        chk("dwell_start", {16'd0, dwell}, 32'd1);
        chk("last_dwell", {16'd0, last_dwell}, exp_last);
        tick(1);
        chk("phase_chg_off", {31'd0, phase_chg}, 32'd0);
        chk("dwell_inc", {16'd0, dwell}, 32'd2);
        tick(n - 3);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b0;
        light = 10'h011;
        seq_check_en = 1'b1;
        clr_err = 1'b0;
        mirror = 1'b0;
        tick(3);
        chk("rst_phase", {29'd0, phase}, 32'd7);
        chk("rst_chg", {31'd0, phase_chg}, 32'd0);
        chk("rst_dwell", {16'd0, dwell}, 32'd0);
        chk("rst_last", {16'd0, last_dwell}, 32'd0);
        chk("rst_err", {28'd0, err_flags}, 32'd0);

        // Release: phase appears two cycles later
        rst = 1'b1;
        tick(1);
        chk("fill_phase", {29'd0, phase}, 32'd7);
        tick(1);
        chk("init_phase", {29'd0, phase}, 32'd0);
        chk("init_chg", {31'd0, phase_chg}, 32'd1);
        chk("init_dwell", {16'd0, dwell}, 32'd1);
        tick(18);

        // Full legal cycle
        drive_phase(10'h114, 40, 3'd1, 20);
        drive_phase(10'h019, 40, 3'd2, 40);
        drive_phase(10'h012, 30, 3'd3, 40);
        drive_phase(10'h011, 20, 3'd0, 30);
        drive_phase(10'h241, 40, 3'd4, 20);
        drive_phase(10'h091, 40, 3'd5, 40);
        drive_phase(10'h021, 30, 3'd6, 40);
        drive_phase(10'h011, 20, 3'd0, 30);
        chk("cycle_err", {28'd0, err_flags}, 32'd0);
        chk("cycle_err_any", {31'd0, err_any}, 32'd0);

        // Left skip: legal with skipping allowed, sequence error without
        mirror = 1'b1;
        drive_phase(10'h114, 40, 3'd1, 20);
        drive_phase(10'h012, 30, 3'd3, 40);
        chk("skip_err", {28'd0, err_flags}, 32'd0);
        chk("noskip_phase", {29'd0, phase_b}, 32'd3);
        chk("noskip_err", {28'd0, err_flags_b}, 32'h2);
        chk("noskip_err_any", {31'd0, err_any_b}, 32'd1);
        mirror = 1'b0;
        drive_phase(10'h011, 20, 3'd0, 30);

        // Short yellow
        drive_phase(10'h114, 40, 3'd1, 20);
        drive_phase(10'h012, 12, 3'd3, 40);
        drive_phase(10'h011, 20, 3'd0, 12);
        chk("short_yel_err", {28'd0, err_flags}, 32'h4);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("clr_err", {28'd0, err_flags}, 32'h0);

        // Conflicting greens, then re-sync into EW_GO without a sequence check
        light = 10'h054;
        tick(2);
        chk("bad_phase", {29'd0, phase}, 32'd7);
        chk("bad_chg", {31'd0, phase_chg}, 32'd1);
        chk("bad_dwell", {16'd0, dwell}, 32'd0);
        chk("bad_last", {16'd0, last_dwell}, 32'd21);
        chk("bad_err", {28'd0, err_flags}, 32'h1);
        tick(1);
        chk("bad_chg_once", {31'd0, phase_chg}, 32'd0);
        drive_phase(10'h241, 40, 3'd4, 21);
        chk("resync_err", {28'd0, err_flags}, 32'h1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;

        // Sequence check disabled
        seq_check_en = 1'b0;
        drive_phase(10'h114, 40, 3'd1, 41);
        drive_phase(10'h241, 40, 3'd4, 40);
        chk("seq_off_err", {28'd0, err_flags}, 32'h0);

        // All-off pattern sets err[0], then short all-red with clr in the same cycle
        light = 10'h000;
        tick(3);
        chk("off_phase", {29'd0, phase}, 32'd7);
        chk("off_dwell", {16'd0, dwell}, 32'd0);
        chk("off_err", {28'd0, err_flags}, 32'h1);
        drive_phase(10'h011, 5, 3'd0, 40);
        light = 10'h241;
        tick(1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("set_vs_clr_err", {28'd0, err_flags}, 32'h8);
        chk("set_vs_clr_any", {31'd0, err_any}, 32'd1);
        chk("short_ar_last", {16'd0, last_dwell}, 32'd5);
        chk("short_ar_phase", {29'd0, phase}, 32'd4);
        seq_check_en = 1'b1;

        // Reset in the middle of EW_GO
        tick(5);
        rst = 1'b0;
        light = 10'h011;
        tick(3);
        chk("mid_rst_phase", {29'd0, phase}, 32'd7);
        chk("mid_rst_chg", {31'd0, phase_chg}, 32'd0);
        chk("mid_rst_dwell", {16'd0, dwell}, 32'd0);
        chk("mid_rst_last", {16'd0, last_dwell}, 32'd0);
        chk("mid_rst_err", {28'd0, err_flags}, 32'd0);
        chk("mid_rst_any", {31'd0, err_any}, 32'd0);
        rst = 1'b1;
        tick(1);
        chk("refill_phase", {29'd0, phase}, 32'd7);
        tick(1);
        chk("refill_phase0", {29'd0, phase}, 32'd0);
        chk("refill_chg", {31'd0, phase_chg}, 32'd1);
        chk("refill_dwell", {16'd0, dwell}, 32'd1);
        chk("refill_err", {28'd0, err_flags}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
